writeback_stage: RTL and testbench

//  Final pipeline stage, directly downstream of the memory stage. Registers the MEM/WB

---
 rtl/writeback_stage.sv | 182 ++++++++++++++++++
 tb/tb_writeback_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Writeback stage: registers the MEM/WB fields, extracts load data from the SRAM read port,
// drives the register-file write port, counts retired instructions and halts on HALT_INSN.
module writeback_stage #(
    parameter int          XLEN      = 32,
    parameter int          CNT_W     = 32,
    parameter logic [31:0] HALT_INSN = 32'h0000_0073
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             EN,
    input  logic             START,
    input  logic             MEM_in_valid,
    input  logic [31:0]      MEM_in_instr,
    input  logic [XLEN-1:0]  MEM_in_ALU_res,
    input  logic [XLEN-1:0]  MEM_in_pc4,
    input  logic [4:0]       MEM_in_rd,
    input  logic             MEM_in_RegWrite,
    input  logic             MEM_in_MemToReg,
    input  logic             MEM_in_Link,
    input  logic [2:0]       MEM_in_funct3,
    input  logic [XLEN-1:0]  MEM_mem_data,
    output logic             WB_RegWrite,
    output logic [4:0]       WB_rd,
    output logic [XLEN-1:0]  WB_wdata,
    output logic             WB_valid,
    output logic             WB_misaligned,
    output logic [CNT_W-1:0] WB_retire_cnt,
    output logic             WB_halted
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    logic              halted_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              valid_r;
    logic [31:0]       instr_r;
    logic [XLEN-1:0]   alu_res_r;
    logic [XLEN-1:0]   pc4_r;
    logic [4:0]        rd_r;
    logic              reg_write_r;
    logic              mem_to_reg_r;
    logic              link_r;
    logic [2:0]        funct3_r;

    logic              advance_s;
    logic              retire_s;
    logic              misaligned_s;
    logic [XLEN-1:0]   load_data_s;
    logic [XLEN-1:0]   wdata_s;

    // Unknown load encodings behave as LW, so only LH/LHU have a relaxed alignment rule.
    function automatic logic load_misaligned(input logic [1:0] off, input logic [2:0] f3);
        logic mis;
        case (f3)
            3'b000, 3'b100: mis = 1'b0;
            3'b001, 3'b101: mis = off[0];
            default:        mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

    function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] data,
                                                     input logic [1:0] off,
                                                     input logic [2:0] f3);
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] res;
        b = data[{off, 3'b000} +: 8];
        h = data[{off[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  res = {{(XLEN-8){b[7]}}, b};
            3'b100:  res = {{(XLEN-8){1'b0}}, b};
            3'b001:  res = {{(XLEN-16){h[15]}}, h};
            3'b101:  res = {{(XLEN-16){1'b0}}, h};
            default: res = data;
        endcase
        return res;
    endfunction

    assign advance_s = EN & START & (state_r != ST_HALT);
    assign retire_s  = EN & START & (state_r == ST_RUN) & valid_r;

    // Run/halt FSM with registered halt flag.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_r  <= ST_IDLE;
            halted_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (START) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                    halted_r <= 1'b0;
                end
                ST_RUN: begin
                    if (retire_s && (instr_r == HALT_INSN)) begin
                        state_r  <= ST_HALT;
                        halted_r <= 1'b1;
                    end else begin
                        state_r  <= ST_RUN;
                        halted_r <= 1'b0;
                    end
                end
                ST_HALT: begin
                    state_r  <= ST_HALT;
                    halted_r <= 1'b1;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    halted_r <= 1'b0;
                end
            endcase
        end
    end

    // MEM/WB pipeline registers, held whenever the pipe does not advance.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            valid_r      <= 1'b0;
            instr_r      <= 32'h0000_0000;
            alu_res_r    <= {XLEN{1'b0}};
            pc4_r        <= {XLEN{1'b0}};
            rd_r         <= 5'd0;
            reg_write_r  <= 1'b0;
            mem_to_reg_r <= 1'b0;
            link_r       <= 1'b0;
            funct3_r     <= 3'b000;
        end else if (advance_s) begin
            valid_r      <= MEM_in_valid;
            instr_r      <= MEM_in_instr;
            alu_res_r    <= MEM_in_ALU_res;
            pc4_r        <= MEM_in_pc4;
            rd_r         <= MEM_in_rd;
            reg_write_r  <= MEM_in_RegWrite;
            mem_to_reg_r <= MEM_in_MemToReg;
            link_r       <= MEM_in_Link;
            funct3_r     <= MEM_in_funct3;
        end
    end

    // Retire counter: one count per instruction leaving the WB slot, wraps freely.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (retire_s) begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // Write-data select; SRAM data arrives this cycle so it is used unregistered.
    always_comb begin
        load_data_s  = load_extract(MEM_mem_data, alu_res_r[1:0], funct3_r);
        misaligned_s = valid_r & mem_to_reg_r & load_misaligned(alu_res_r[1:0], funct3_r);
        wdata_s      = alu_res_r;
        if (link_r) begin
            wdata_s = pc4_r;
        end else if (mem_to_reg_r) begin
            wdata_s = load_data_s;
        end else begin
            wdata_s = alu_res_r;
        end
    end

    assign WB_RegWrite   = valid_r & reg_write_r & (rd_r != 5'd0) & ~misaligned_s & (state_r == ST_RUN);
    assign WB_rd         = rd_r;
    assign WB_wdata      = wdata_s;
    assign WB_valid      = valid_r;
    assign WB_misaligned = misaligned_s;
    assign WB_retire_cnt = cnt_r;
    assign WB_halted     = halted_r;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: loads, link, rd=0, bubbles, halt, counter wrap, async reset.
module tb_writeback_stage;

    logic        CLK = 1'b0;
    logic        RSTn, EN, START;
    logic        MEM_in_valid, MEM_in_RegWrite, MEM_in_MemToReg, MEM_in_Link;
    logic [31:0] MEM_in_instr, MEM_in_ALU_res, MEM_in_pc4, MEM_mem_data;
    logic [4:0]  MEM_in_rd;
    logic [2:0]  MEM_in_funct3;

    logic        WB_RegWrite, WB_valid, WB_misaligned, WB_halted;
    logic [4:0]  WB_rd;
    logic [31:0] WB_wdata, WB_retire_cnt;

    logic        s_RegWrite, s_valid, s_misaligned, s_halted;
    logic [4:0]  s_rd;
    logic [31:0] s_wdata;
    logic [3:0]  s_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    writeback_stage u_dut (
        .CLK(CLK), .RSTn(RSTn), .EN(EN), .START(START),
        .MEM_in_valid(MEM_in_valid), .MEM_in_instr(MEM_in_instr),
        .MEM_in_ALU_res(MEM_in_ALU_res), .MEM_in_pc4(MEM_in_pc4), .MEM_in_rd(MEM_in_rd),
        .MEM_in_RegWrite(MEM_in_RegWrite), .MEM_in_MemToReg(MEM_in_MemToReg),
        .MEM_in_Link(MEM_in_Link), .MEM_in_funct3(MEM_in_funct3), .MEM_mem_data(MEM_mem_data),
        .WB_RegWrite(WB_RegWrite), .WB_rd(WB_rd), .WB_wdata(WB_wdata), .WB_valid(WB_valid),
        .WB_misaligned(WB_misaligned), .WB_retire_cnt(WB_retire_cnt), .WB_halted(WB_halted)
    );

    writeback_stage #(.CNT_W(4)) u_small (
        .CLK(CLK), .RSTn(RSTn), .EN(EN), .START(START),
        .MEM_in_valid(MEM_in_valid), .MEM_in_instr(MEM_in_instr),
        .MEM_in_ALU_res(MEM_in_ALU_res), .MEM_in_pc4(MEM_in_pc4), .MEM_in_rd(MEM_in_rd),
        .MEM_in_RegWrite(MEM_in_RegWrite), .MEM_in_MemToReg(MEM_in_MemToReg),
        .MEM_in_Link(MEM_in_Link), .MEM_in_funct3(MEM_in_funct3), .MEM_mem_data(MEM_mem_data),
        .WB_RegWrite(s_RegWrite), .WB_rd(s_rd), .WB_wdata(s_wdata), .WB_valid(s_valid),
        .WB_misaligned(s_misaligned), .WB_retire_cnt(s_cnt), .WB_halted(s_halted)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one MEM-stage slot and clock it into WB; returns #1 after the edge.
    task automatic issue(input logic v, input logic [31:0] instr, input logic [31:0] alu,
                         input logic [31:0] pc4, input logic [4:0] rd, input logic rw,
                         input logic m2r, input logic lnk, input logic [2:0] f3);
        MEM_in_valid    = v;
        MEM_in_instr    = instr;
        MEM_in_ALU_res  = alu;
        MEM_in_pc4      = pc4;
        MEM_in_rd       = rd;
        MEM_in_RegWrite = rw;
        MEM_in_MemToReg = m2r;
        MEM_in_Link     = lnk;
        MEM_in_funct3   = f3;
        @(posedge CLK);
        #1;
    endtask

    task automatic check_zero_outputs(input string pfx);
        check_eq({pfx, "_regwrite"}, {31'd0, WB_RegWrite}, 32'd0);
        check_eq({pfx, "_rd"}, {27'd0, WB_rd}, 32'd0);
        check_eq({pfx, "_wdata"}, WB_wdata, 32'd0);
        check_eq({pfx, "_valid"}, {31'd0, WB_valid}, 32'd0);
        check_eq({pfx, "_misal"}, {31'd0, WB_misaligned}, 32'd0);
        check_eq({pfx, "_cnt"}, WB_retire_cnt, 32'd0);
        check_eq({pfx, "_halted"}, {31'd0, WB_halted}, 32'd0);
        check_eq({pfx, "_s_all"}, {s_RegWrite, s_rd, s_valid, s_misaligned, s_halted, s_cnt, s_wdata[15:0]}, 32'd0);
    endtask

    localparam logic [31:0] ADDI  = 32'h02A0_0293;
    localparam logic [31:0] LOAD  = 32'h0000_0003;
    localparam logic [31:0] JAL   = 32'h0040_00EF;
    localparam logic [31:0] ECALL = 32'h0000_0073;

    initial begin
        RSTn = 1'b0; EN = 1'b0; START = 1'b0; MEM_mem_data = 32'd0;
        MEM_in_valid = 1'b0; MEM_in_instr = 32'd0; MEM_in_ALU_res = 32'd0; MEM_in_pc4 = 32'd0;
        MEM_in_rd = 5'd0; MEM_in_RegWrite = 1'b0; MEM_in_MemToReg = 1'b0; MEM_in_Link = 1'b0;
        MEM_in_funct3 = 3'd0;
        #12;
        check_zero_outputs("reset");
        RSTn = 1'b1; EN = 1'b1; START = 1'b1;

        // ADDI x5 = 0x2A
        issue(1'b1, ADDI, 32'h2A, 32'h100, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000);
        check_eq("addi_regwrite", {31'd0, WB_RegWrite}, 32'd1);
        check_eq("addi_rd", {27'd0, WB_rd}, 32'd5);
        check_eq("addi_wdata", WB_wdata, 32'h2A);
        check_eq("addi_cnt_before_retire", WB_retire_cnt, 32'd0);

        // LB from byte 2 of 0x1280FF34 -> 0x80 sign-extended
        issue(1'b1, LOAD, 32'h1E, 32'h104, 5'd6, 1'b1, 1'b1, 1'b0, 3'b000);
        MEM_mem_data = 32'h1280_FF34; #1;
        check_eq("lb_wdata", WB_wdata, 32'hFFFF_FF80);
        check_eq("lb_regwrite", {31'd0, WB_RegWrite}, 32'd1);
        check_eq("cnt_after_addi", WB_retire_cnt, 32'd1);

        issue(1'b1, LOAD, 32'h1E, 32'h108, 5'd6, 1'b1, 1'b1, 1'b0, 3'b100);
        MEM_mem_data = 32'h1280_FF34; #1;
        check_eq("lbu_wdata", WB_wdata, 32'h0000_0080);

        // LB byte 1 -> 0xFF
        issue(1'b1, LOAD, 32'h1D, 32'h10C, 5'd6, 1'b1, 1'b1, 1'b0, 3'b000);
        MEM_mem_data = 32'h1280_FF34; #1;
        check_eq("lb_off1_wdata", WB_wdata, 32'hFFFF_FFFF);

        issue(1'b1, LOAD, 32'h1F, 32'h110, 5'd7, 1'b1, 1'b1, 1'b0, 3'b001);
        MEM_mem_data = 32'h1280_FF34; #1;
        check_eq("lh_misal_flag", {31'd0, WB_misaligned}, 32'd1);
        check_eq("lh_misal_regwrite", {31'd0, WB_RegWrite}, 32'd0);

        issue(1'b1, LOAD, 32'h1C, 32'h114, 5'd8, 1'b1, 1'b1, 1'b0, 3'b010);
        MEM_mem_data = 32'h0000_0002; #1;
        check_eq("lw_wdata", WB_wdata, 32'h2);
        check_eq("lw_misal", {31'd0, WB_misaligned}, 32'd0);
        check_eq("lw_regwrite", {31'd0, WB_RegWrite}, 32'd1);

        issue(1'b1, LOAD, 32'h1E, 32'h118, 5'd8, 1'b1, 1'b1, 1'b0, 3'b010);
        MEM_mem_data = 32'h0000_0002; #1;
        check_eq("lw_misal_flag", {31'd0, WB_misaligned}, 32'd1);

        issue(1'b1, LOAD, 32'h1E, 32'h11C, 5'd9, 1'b1, 1'b1, 1'b0, 3'b001);
        MEM_mem_data = 32'h1280_FF34; #1;
        check_eq("lh_hi_wdata", WB_wdata, 32'h0000_1280);

        issue(1'b1, LOAD, 32'h1C, 32'h120, 5'd9, 1'b1, 1'b1, 1'b0, 3'b001);
        MEM_mem_data = 32'h0000_8001; #1;
        check_eq("lh_neg_wdata", WB_wdata, 32'hFFFF_8001);

        issue(1'b1, LOAD, 32'h1C, 32'h124, 5'd9, 1'b1, 1'b1, 1'b0, 3'b101);
        MEM_mem_data = 32'h0000_8001; #1;
        check_eq("lhu_wdata", WB_wdata, 32'h0000_8001);

        issue(1'b1, ADDI, 32'h55, 32'h128, 5'd0, 1'b1, 1'b0, 1'b0, 3'b000);
        check_eq("rd0_regwrite", {31'd0, WB_RegWrite}, 32'd0);
        check_eq("rd0_wdata", WB_wdata, 32'h55);
        check_eq("cnt_before_rd0", WB_retire_cnt, 32'd10);

        issue(1'b1, JAL, 32'h999, 32'h104, 5'd1, 1'b1, 1'b0, 1'b1, 3'b000);
        check_eq("jal_wdata", WB_wdata, 32'h104);
        check_eq("jal_regwrite", {31'd0, WB_RegWrite}, 32'd1);
        check_eq("cnt_rd0_counted", WB_retire_cnt, 32'd11);

        issue(1'b0, ADDI, 32'h33, 32'h12C, 5'd3, 1'b1, 1'b0, 1'b0, 3'b000);
        check_eq("bubble_valid", {31'd0, WB_valid}, 32'd0);
        check_eq("bubble_regwrite", {31'd0, WB_RegWrite}, 32'd0);
        check_eq("cnt_after_jal", WB_retire_cnt, 32'd12);

        // EN low: slot holds, bubble not counted
        EN = 1'b0;
        issue(1'b1, ADDI, 32'h44, 32'h130, 5'd4, 1'b1, 1'b0, 1'b0, 3'b000);
        check_eq("hold_valid", {31'd0, WB_valid}, 32'd0);
        check_eq("hold_cnt", WB_retire_cnt, 32'd12);
        EN = 1'b1;

        issue(1'b1, ECALL, 32'h0, 32'h134, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000);
        check_eq("ecall_in_wb_halted", {31'd0, WB_halted}, 32'd0);
        check_eq("ecall_cnt", WB_retire_cnt, 32'd12);

        issue(1'b1, ADDI, 32'h77, 32'h138, 5'd7, 1'b1, 1'b0, 1'b0, 3'b000);
        check_eq("halt_halted", {31'd0, WB_halted}, 32'd1);
        check_eq("halt_regwrite", {31'd0, WB_RegWrite}, 32'd0);
        check_eq("halt_cnt", WB_retire_cnt, 32'd13);

        issue(1'b1, ADDI, 32'h88, 32'h13C, 5'd8, 1'b1, 1'b0, 1'b0, 3'b000);
        check_eq("halt_sticky", {31'd0, WB_halted}, 32'd1);
        check_eq("halt_frozen_wdata", WB_wdata, 32'h77);
        check_eq("halt_frozen_cnt", WB_retire_cnt, 32'd13);
        check_eq("halt_frozen_regwrite", {31'd0, WB_RegWrite}, 32'd0);

        // Fresh run: counter wrap on the 4-bit instance, then async reset mid-run
        RSTn = 1'b0; #1;
        check_zero_outputs("rst2");
        RSTn = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            issue(1'b1, ADDI, 32'(i), 32'h200, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000);
            if (i == 15) begin
                check_eq("small_cnt_max", {28'd0, s_cnt}, 32'd15);
            end else if (i == 16) begin
                check_eq("small_cnt_wrap", {28'd0, s_cnt}, 32'd0);
                check_eq("big_cnt_16", WB_retire_cnt, 32'd16);
            end
        end
        check_eq("prerst_regwrite", {31'd0, WB_RegWrite}, 32'd1);
        check_eq("prerst_small_regwrite", {31'd0, s_RegWrite}, 32'd1);
        check_eq("prerst_small_wdata", s_wdata, 32'd16);
        #2;
        RSTn = 1'b0; #1;
        check_zero_outputs("midrun_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
